// File: rtl/pipe_ctrl_gen.sv
// rtl/pipe_ctrl_gen.sv - pipeline stall/hold/flush controller with prefix stall lanes.
// Drives stage-register stall lanes, a one-cycle flush and the redirect PC.
module pipe_ctrl_gen #(
  parameter int STAGES = 6,
  parameter int SIDX_W = 3,
  parameter int HOLD_W = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              hold_req,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [SIDX_W-1:0] hold_stage,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_vec,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nx;
  logic [SIDX_W-1:0] hstage;
  logic [SIDX_W-1:0] hstage_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [SIDX_W-1:0] hold_stage_c;
  logic [STAGES-1:0] req_mask;
  logic [STAGES-1:0] hold_mask;

  always_comb begin
    if (int'(hold_stage) >= STAGES) hold_stage_c = SIDX_W'(STAGES - 1);
    else                            hold_stage_c = hold_stage;
  end

  // A stalled stage must also freeze every stage upstream of it.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc         = acc | stallreq[i];
      req_mask[i] = acc;
    end
  end

  always_comb begin
    hold_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      hold_mask[i] = (state == HOLD) && (i <= int'(hstage));
    end
  end

  always_comb begin
    if (rst || state == FLUSH) stall = '0;
    else                       stall = req_mask | hold_mask;
  end

  assign flush = !rst && (state == FLUSH);
  assign busy  = !rst && (state != IDLE);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hstage_nx = hstage;
    pc_nx     = new_pc;
    case (state)
      IDLE: begin
        if (excp_req) begin
          state_nx = FLUSH;
          pc_nx    = excp_vec;
        end else if (hold_req && hold_cycles != '0) begin
          state_nx  = HOLD;
          cnt_nx    = hold_cycles;
          hstage_nx = hold_stage_c;
        end
      end
      HOLD: begin
        if (excp_req) begin
          state_nx = FLUSH;
          pc_nx    = excp_vec;
          cnt_nx   = '0;
        end else if (cnt == HOLD_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - HOLD_W'(1);
        end
      end
      FLUSH: begin
        // Back-to-back exceptions keep flushing and take the newest vector.
        if (excp_req) begin
          state_nx = FLUSH;
          pc_nx    = excp_vec;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hstage <= '0;
      new_pc <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      hstage <= hstage_nx;
      new_pc <= pc_nx;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb/tb_pipe_ctrl_gen.sv - self-checking bench for pipe_ctrl_gen.
// Table vectors, hand sequences and random stimulus against a behavioural model.
module tb_pipe_ctrl_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq;
  logic        hold_req;
  logic [3:0]  hold_cycles;
  logic [2:0]  hold_stage;
  logic        excp_req;
  logic [31:0] excp_vec;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: remaining hold cycles, frozen depth, flush pending, redirect target.
  int          m_hold_left;
  int          m_hstage;
  bit          m_flush;
  logic [31:0] m_pc;

  typedef struct {
    logic [5:0] sr;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[8];

  pipe_ctrl_gen #(.STAGES(6), .SIDX_W(3), .HOLD_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .hold_req(hold_req),
    .hold_cycles(hold_cycles), .hold_stage(hold_stage), .excp_req(excp_req),
    .excp_vec(excp_vec), .stall(stall), .flush(flush), .new_pc(new_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pmask(input int k);
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [5:0] model_stall();
    int h;
    h = -1;
    if (rst || m_flush) return 6'd0;
    for (int i = 0; i < 6; i++) if (stallreq[i]) h = i;
    return pmask(h) | ((m_hold_left > 0) ? pmask(m_hstage) : 6'd0);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_hold_left = 0; m_hstage = 0; m_flush = 0; m_pc = 32'd0;
    end else if (excp_req) begin
      m_flush = 1; m_pc = excp_vec; m_hold_left = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (hold_req && hold_cycles != 4'd0) begin
      m_hold_left = int'(hold_cycles);
      m_hstage    = (int'(hold_stage) > 5) ? 5 : int'(hold_stage);
    end
  endtask

  // Drive inputs (called at the falling edge), let them settle, compare with the model.
  task automatic set_in(input logic r, input logic [5:0] sr, input logic hr,
                        input logic [3:0] hc, input logic [2:0] hs,
                        input logic er, input logic [31:0] ev);
    rst = r; stallreq = sr; hold_req = hr; hold_cycles = hc;
    hold_stage = hs; excp_req = er; excp_vec = ev;
    #1;
    chk("model_stall", {26'd0, stall}, {26'd0, model_stall()});
    chk("model_flush", {31'd0, flush}, {31'd0, (!rst && m_flush)});
    chk("model_busy", {31'd0, busy}, {31'd0, (!rst && (m_flush || m_hold_left > 0))});
    chk("model_new_pc", new_pc, m_pc);
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    set_in(1'b0, 6'd0, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
  endtask

  initial begin
    vecs[0] = '{6'b001000, 6'b001111};
    vecs[1] = '{6'b001100, 6'b001111};
    vecs[2] = '{6'b000100, 6'b000111};
    vecs[3] = '{6'b000000, 6'b000000};
    vecs[4] = '{6'b000001, 6'b000001};
    vecs[5] = '{6'b100000, 6'b111111};
    vecs[6] = '{6'b010101, 6'b011111};
    vecs[7] = '{6'b000010, 6'b000011};

    rst = 1'b1; stallreq = '0; hold_req = 0; hold_cycles = '0; hold_stage = '0;
    excp_req = 0; excp_vec = '0;
    m_hold_left = 0; m_hstage = 0; m_flush = 0; m_pc = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state
    set_in(1'b1, 6'b111111, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    edge_();

    // 1: prefix stall table, same-cycle response
    foreach (vecs[i]) begin
      set_in(1'b0, vecs[i].sr, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
      chk("tbl_stall", {26'd0, stall}, {26'd0, vecs[i].exp});
      chk("tbl_busy", {31'd0, busy}, 32'd0);
      edge_();
    end

    // 2: timed hold of 3 cycles
    set_in(1'b0, 6'd0, 1'b1, 4'd3, 3'd3, 1'b0, 32'd0);
    chk("h2_c0_busy", {31'd0, busy}, 32'd0);
    edge_();
    idle_in();
    chk("h2_c1_stall", {26'd0, stall}, 32'h0f);
    chk("h2_c1_busy", {31'd0, busy}, 32'd1);
    edge_();
    set_in(1'b0, 6'b010000, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
    chk("h2_c2_stall", {26'd0, stall}, 32'h1f);
    edge_();
    idle_in();
    chk("h2_c3_stall", {26'd0, stall}, 32'h0f);
    chk("h2_c3_busy", {31'd0, busy}, 32'd1);
    edge_();
    idle_in();
    chk("h2_c4_stall", {26'd0, stall}, 32'd0);
    chk("h2_c4_busy", {31'd0, busy}, 32'd0);
    edge_();

    // 3: exception aborts a hold
    set_in(1'b0, 6'd0, 1'b1, 4'd3, 3'd3, 1'b0, 32'd0);
    edge_();
    idle_in();
    edge_();
    set_in(1'b0, 6'd0, 1'b0, 4'd0, 3'd0, 1'b1, 32'h20);
    chk("h3_c2_stall", {26'd0, stall}, 32'h0f);
    edge_();
    set_in(1'b0, 6'b111111, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
    chk("h3_c3_flush", {31'd0, flush}, 32'd1);
    chk("h3_c3_new_pc", new_pc, 32'h20);
    chk("h3_c3_stall", {26'd0, stall}, 32'd0);
    edge_();
    idle_in();
    chk("h3_c4_busy", {31'd0, busy}, 32'd0);
    chk("h3_c4_stall", {26'd0, stall}, 32'd0);
    edge_();
    idle_in();
    chk("h3_c5_busy", {31'd0, busy}, 32'd0);
    edge_();

    // 4: exception beats hold; back-to-back exceptions
    set_in(1'b0, 6'd0, 1'b1, 4'd5, 3'd2, 1'b1, 32'h20);
    edge_();
    idle_in();
    chk("h4_flush", {31'd0, flush}, 32'd1);
    edge_();
    idle_in();
    chk("h4_nohold_busy", {31'd0, busy}, 32'd0);
    chk("h4_nohold_stall", {26'd0, stall}, 32'd0);
    set_in(1'b0, 6'd0, 1'b0, 4'd0, 3'd0, 1'b1, 32'h20);
    edge_();
    set_in(1'b0, 6'd0, 1'b0, 4'd0, 3'd0, 1'b1, 32'h180);
    chk("h4_b2b1_flush", {31'd0, flush}, 32'd1);
    chk("h4_b2b1_pc", new_pc, 32'h20);
    edge_();
    idle_in();
    chk("h4_b2b2_flush", {31'd0, flush}, 32'd1);
    chk("h4_b2b2_pc", new_pc, 32'h180);
    edge_();
    idle_in();
    chk("h4_after_flush", {31'd0, flush}, 32'd0);
    chk("h4_after_pc", new_pc, 32'h180);
    edge_();

    // 5: zero-length hold ignored; out-of-range stage clamped
    set_in(1'b0, 6'd0, 1'b1, 4'd0, 3'd4, 1'b0, 32'd0);
    edge_();
    idle_in();
    chk("h5_zero_busy", {31'd0, busy}, 32'd0);
    chk("h5_zero_stall", {26'd0, stall}, 32'd0);
    set_in(1'b0, 6'd0, 1'b1, 4'd1, 3'd7, 1'b0, 32'd0);
    edge_();
    idle_in();
    chk("h5_clamp_stall", {26'd0, stall}, 32'h3f);
    edge_();
    idle_in();
    chk("h5_clamp_end", {26'd0, stall}, 32'd0);
    chk("h5_clamp_busy", {31'd0, busy}, 32'd0);
    edge_();

    // 6: reset in the middle of a long hold
    set_in(1'b0, 6'd0, 1'b1, 4'd10, 3'd2, 1'b0, 32'd0);
    edge_();
    for (int i = 0; i < 3; i++) begin
      idle_in();
      chk("h6_hold_stall", {26'd0, stall}, 32'h07);
      edge_();
    end
    set_in(1'b1, 6'b111111, 1'b0, 4'd0, 3'd0, 1'b0, 32'd0);
    chk("h6_rst_stall", {26'd0, stall}, 32'd0);
    edge_();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      chk("h6_post_busy", {31'd0, busy}, 32'd0);
      chk("h6_post_flush", {31'd0, flush}, 32'd0);
      chk("h6_post_pc", new_pc, 32'd0);
      chk("h6_post_stall", {26'd0, stall}, 32'd0);
      edge_();
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 39) == 0),
             ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom),
             ($urandom_range(0, 4) == 0),
             4'($urandom_range(0, 12)),
             3'($urandom),
             ($urandom_range(0, 11) == 0),
             $urandom);
      edge_();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
